// File: rtl/pe_pkg.sv
// Shared constants for the processing-element slice: default widths and
// the scratchpad memory map used by the PE control FSM.
package pe_pkg;

    localparam int unsigned PE_DATA_WIDTH    = 16;
    localparam int unsigned PE_ADDRESS_WIDTH = 9;

    // Scratchpad regions
    localparam int unsigned WEIGHT_BASE      = 0;
    localparam int unsigned ACTIVATION_BASE  = 100;
    localparam int unsigned PSUM_BASE        = 500;

endpackage

// File: rtl/pe_spad.sv
// PE scratchpad: one write port and one registered read port.
// Contents are not cleared by reset; only the read register is.
module pe_spad
    import pe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = PE_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = PE_ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     read_request,
    input  logic [ADDRESS_WIDTH-1:0] read_address,
    output logic [DATA_WIDTH-1:0]    read_data,
    input  logic                     write_enable,
    input  logic [ADDRESS_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0]    write_data
);

    localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Array write; reset blocks the write so a reset edge changes no contents
    always_ff @(posedge clk) begin
        if (write_enable && !reset) begin
            mem[write_address] <= write_data;
        end
    end

    // Registered read; samples the pre-write contents (read-before-write)
    always_ff @(posedge clk) begin
        if (reset) begin
            read_data <= '0;
        end else if (read_request) begin
            read_data <= mem[read_address];
        end
    end

endmodule

// File: rtl/pe_datapath.sv
// PE datapath: scratchpad, multiply-accumulate register and the
// accumulator feedback select. All control comes from the PE FSM.
module pe_datapath
    import pe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = PE_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = PE_ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     read_request,
    input  logic [ADDRESS_WIDTH-1:0] read_address,
    output logic [DATA_WIDTH-1:0]    read_data,
    input  logic                     write_enable,
    input  logic [ADDRESS_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic [DATA_WIDTH-1:0]    a_in,
    input  logic [DATA_WIDTH-1:0]    w_in,
    input  logic                     mac_enable,
    input  logic                     acc_sel,
    output logic [DATA_WIDTH-1:0]    mac_out
);

    logic [DATA_WIDTH-1:0] sum_in;
    logic [DATA_WIDTH-1:0] mac_next;

    pe_spad #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_spad (
        .clk           (clk),
        .reset         (reset),
        .read_request  (read_request),
        .read_address  (read_address),
        .read_data     (read_data),
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_data    (write_data)
    );

    // Feedback select and next partial sum; evaluating at DATA_WIDTH gives
    // the same low bits as forming the full product and truncating after
    always_comb begin
        sum_in   = acc_sel ? mac_out : '0;
        mac_next = a_in * w_in + sum_in;
    end

    // MAC result register, fed back through sum_in
    always_ff @(posedge clk) begin
        if (reset) begin
            mac_out <= '0;
        end else if (mac_enable) begin
            mac_out <= mac_next;
        end
    end

endmodule

// File: tb/tb_pe_datapath.sv
// Bench for pe_datapath: directed scenarios with literal expectations,
// then randomized traffic checked against a behavioural model every cycle.
module tb_pe_datapath;
    import pe_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        read_request;
    logic [8:0]  read_address;
    logic [15:0] read_data;
    logic        write_enable;
    logic [8:0]  write_address;
    logic [15:0] write_data;
    logic [15:0] a_in;
    logic [15:0] w_in;
    logic        mac_enable;
    logic        acc_sel;
    logic [15:0] mac_out;

    int unsigned total = 0;
    int unsigned bad   = 0;
    bit          checking = 1'b0;

    // Behavioural model state
    logic [15:0] model_mem [512];
    bit          model_valid [512];
    logic [15:0] exp_rd;
    logic [15:0] exp_mac;

    always #5 clk = ~clk;

    pe_datapath dut (
        .clk           (clk),
        .reset         (reset),
        .read_request  (read_request),
        .read_address  (read_address),
        .read_data     (read_data),
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_data    (write_data),
        .a_in          (a_in),
        .w_in          (w_in),
        .mac_enable    (mac_enable),
        .acc_sel       (acc_sel),
        .mac_out       (mac_out)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Apply one clock edge to the model using the currently driven inputs
    task automatic model_edge();
        longint prod;
        longint acc;
        if (reset) begin
            exp_rd  = 16'd0;
            exp_mac = 16'd0;
        end else begin
            if (read_request) exp_rd = model_mem[read_address];
            if (write_enable) begin
                model_mem[write_address]   = write_data;
                model_valid[write_address] = 1'b1;
            end
            if (mac_enable) begin
                prod    = longint'(a_in) * longint'(w_in);
                acc     = acc_sel ? longint'(exp_mac) : 64'd0;
                exp_mac = 16'((prod + acc) % 65536);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        reset        = 1'b0;
        read_request = 1'b0;
        write_enable = 1'b0;
        mac_enable   = 1'b0;
        acc_sel      = 1'b0;
    endtask

    task automatic mac(input logic [15:0] a, input logic [15:0] w, input logic acc);
        idle();
        a_in = a; w_in = w; acc_sel = acc; mac_enable = 1'b1;
        step();
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (checking) begin
            check("model_read_data", read_data, exp_rd);
            check("model_mac_out", mac_out, exp_mac);
        end
    end

    initial begin
        logic [8:0] bases [3];
        bases[0] = 9'(WEIGHT_BASE);
        bases[1] = 9'(ACTIVATION_BASE);
        bases[2] = 9'(PSUM_BASE);
        for (int i = 0; i < 512; i++) model_valid[i] = 1'b0;
        exp_rd = 16'd0; exp_mac = 16'd0;
        a_in = '0; w_in = '0; read_address = '0; write_address = '0; write_data = '0;
        idle();
        reset = 1'b1;
        step();
        step();
        checking = 1'b1;
        check("reset_read_data", read_data, 16'd0);
        check("reset_mac_out", mac_out, 16'd0);

        // Write then read, then hold
        idle(); write_enable = 1'b1; write_address = 9'(WEIGHT_BASE); write_data = 16'd3;
        step();
        idle(); read_request = 1'b1; read_address = 9'(WEIGHT_BASE);
        step();
        check("read_after_write", read_data, 16'd3);
        idle(); read_address = 9'd5;
        step(); step();
        check("read_hold", read_data, 16'd3);

        // Read-before-write on the same address
        idle(); write_enable = 1'b1; write_address = 9'(ACTIVATION_BASE); write_data = 16'd7;
        step();
        idle(); write_enable = 1'b1; write_address = 9'(ACTIVATION_BASE); write_data = 16'd9;
        read_request = 1'b1; read_address = 9'(ACTIVATION_BASE);
        step();
        check("read_before_write", read_data, 16'd7);
        idle(); read_request = 1'b1; read_address = 9'(ACTIVATION_BASE);
        step();
        check("read_new_value", read_data, 16'd9);

        // Accumulation sequence
        mac(16'd2, 16'd3, 1'b0);   check("mac_first_tap", mac_out, 16'd6);
        mac(16'd4, 16'd5, 1'b1);   check("mac_accumulate", mac_out, 16'd26);
        mac(16'd1, 16'd1, 1'b0);   check("mac_restart", mac_out, 16'd1);
        mac(16'd300, 16'd300, 1'b0); check("mac_product_trunc", mac_out, 16'd24464);
        mac(16'd65535, 16'd1, 1'b0); check("mac_preset_max", mac_out, 16'd65535);
        mac(16'd1, 16'd1, 1'b1);   check("mac_wrap", mac_out, 16'd0);
        mac(16'd2, 16'd3, 1'b0);   check("mac_before_hold", mac_out, 16'd6);

        // Hold with mac_enable low and changing operands
        for (int i = 0; i < 5; i++) begin
            idle(); a_in = 16'($urandom); w_in = 16'($urandom); acc_sel = 1'($urandom);
            step();
            check("mac_hold", mac_out, 16'd6);
        end

        // Reset mid-accumulation; a write presented during reset is dropped
        idle(); read_request = 1'b1; read_address = 9'(WEIGHT_BASE);
        step();
        mac(16'd2, 16'd3, 1'b0);
        mac(16'd4, 16'd5, 1'b1);
        check("pre_reset_mac", mac_out, 16'd26);
        check("pre_reset_read", read_data, 16'd3);
        idle(); reset = 1'b1; mac_enable = 1'b1; acc_sel = 1'b1;
        write_enable = 1'b1; write_address = 9'(WEIGHT_BASE); write_data = 16'd55;
        read_request = 1'b1; read_address = 9'(WEIGHT_BASE);
        step();
        check("reset_mid_mac", mac_out, 16'd0);
        check("reset_mid_read", read_data, 16'd0);
        idle(); read_request = 1'b1; read_address = 9'(WEIGHT_BASE);
        step();
        check("memory_retained", read_data, 16'd3);

        // Randomized traffic concentrated on a few addresses per region
        for (int n = 0; n < 400; n++) begin
            idle();
            reset         = ($urandom_range(0, 49) == 0);
            write_enable  = 1'($urandom);
            write_address = bases[$urandom_range(0, 2)] + 9'($urandom_range(0, 7));
            write_data    = 16'($urandom);
            read_address  = bases[$urandom_range(0, 2)] + 9'($urandom_range(0, 7));
            read_request  = 1'($urandom) && model_valid[read_address];
            mac_enable    = ($urandom_range(0, 3) != 0);
            acc_sel       = ($urandom_range(0, 4) != 0);
            a_in          = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
            w_in          = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
            step();
        end

        idle();
        step();
        @(negedge clk);
        #1;
        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
